// File: rtl/axil2sir_bridge.sv
// rtl/axil2sir_bridge.sv - AXI4-Lite slave to Sir register-bus master bridge
//
// Purpose:
//   Turns each AXI4-Lite read or write into exactly one Sir register access.
//   The bridge sequences every access as IDLE -> ACC -> RESP -> GAP.
//   SirSel is held for at least SEL_HOLD cycles and stays low for at least SEL_GAP cycles
//   between accesses, which lets slave edge detectors commit and rearm.
//   An access that never sees SirDack ends after TIMEOUT cycles with SLVERR.
//   A read that ends this way returns ERRDATA.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*              AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                   AXI4-Lite read address/data channels
//   SirSel/SirRead/SirAddr/SirWdat   Sir access request, stable while SirSel=1
//   SirDack/SirRdat              OR-ed slave acknowledge and read data

module axil2sir_bridge #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32,
    parameter int SEL_HOLD  = 3,
    parameter int SEL_GAP   = 2,
    parameter int TIMEOUT   = 255,
    parameter logic [DATAWIDTH-1:0] ERRDATA = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [ADDRWIDTH-1:0] s_awaddr,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [DATAWIDTH-1:0] s_wdata,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [ADDRWIDTH-1:0] s_araddr,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [DATAWIDTH-1:0] s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 SirSel,
    output logic                 SirRead,
    output logic [ADDRWIDTH-1:0] SirAddr,
    output logic [DATAWIDTH-1:0] SirWdat,
    input  logic                 SirDack,
    input  logic [DATAWIDTH-1:0] SirRdat
);

    localparam int CNTMAX = (TIMEOUT > SEL_HOLD) ? TIMEOUT : SEL_HOLD;
    localparam int CW     = $clog2(CNTMAX) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(SEL_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(SEL_GAP - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, ACC, RESP, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;          // ACC hold/timeout counter, reused as GAP counter
    logic          ackSeen;
    logic          isRead;
    logic          preferWrite;  // round-robin token, write wins first after reset

    logic wrElig, rdElig, pickWrite, pickRead, ackNow;

    always_comb begin
        wrElig    = s_awvalid & s_wvalid;
        rdElig    = s_arvalid;
        pickWrite = wrElig & (!rdElig | preferWrite);
        pickRead  = rdElig & !pickWrite;
        // An ack arriving in the last hold cycle still completes without an extra cycle.
        ackNow    = ackSeen | SirDack;
    end

    // Ready is a one-cycle pulse in the accept cycle, coincident with the winning valid.
    assign s_awready = (state == IDLE) & pickWrite;
    assign s_wready  = (state == IDLE) & pickWrite;
    assign s_arready = (state == IDLE) & pickRead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ackSeen     <= 1'b0;
            isRead      <= 1'b0;
            preferWrite <= 1'b1;
            SirSel      <= 1'b0;
            SirRead     <= 1'b0;
            SirAddr     <= '0;
            SirWdat     <= '0;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            s_rvalid    <= 1'b0;
            s_rresp     <= RESP_OKAY;
            s_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    ackSeen <= 1'b0;
                    if (pickWrite) begin
                        SirSel      <= 1'b1;
                        SirRead     <= 1'b0;
                        SirAddr     <= s_awaddr;
                        SirWdat     <= s_wdata;
                        isRead      <= 1'b0;
                        preferWrite <= 1'b0;
                        state       <= ACC;
                    end else if (pickRead) begin
                        SirSel      <= 1'b1;
                        SirRead     <= 1'b1;
                        SirAddr     <= s_araddr;
                        SirWdat     <= '0;
                        isRead      <= 1'b1;
                        preferWrite <= 1'b1;
                        state       <= ACC;
                    end
                end

                ACC: begin
                    if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Only the first ack of an access carries data; later ones are ignored.
                    if (SirDack && !ackSeen) begin
                        ackSeen <= 1'b1;
                        if (isRead) begin
                            s_rdata <= SirRdat;
                        end
                    end
                    if (ackNow && (cnt >= HOLD_LAST)) begin
                        SirSel <= 1'b0;
                        state  <= RESP;
                        if (isRead) begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= RESP_OKAY;
                        end else begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= RESP_OKAY;
                        end
                    end else if (!ackNow && (cnt == TO_LAST)) begin
                        SirSel <= 1'b0;
                        state  <= RESP;
                        if (isRead) begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= RESP_SLVERR;
                            s_rdata  <= ERRDATA;
                        end else begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= RESP_SLVERR;
                        end
                    end
                end

                RESP: begin
                    if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
                        s_bvalid <= 1'b0;
                        s_rvalid <= 1'b0;
                        cnt      <= '0;
                        state    <= GAP;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil2sir_bridge.sv
// tb/tb_axil2sir_bridge.sv - self-checking bench for axil2sir_bridge

module tb_axil2sir_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
    logic        s_bready = 1'b1, s_rready = 1'b1;
    logic [7:0]  s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        SirSel, SirRead;
    logic [7:0]  SirAddr;
    logic [31:0] SirWdat;
    logic        SirDack = 1'b0;
    logic [31:0] SirRdat = '0;

    always #5 clk = ~clk;

    axil2sir_bridge dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .SirSel(SirSel), .SirRead(SirRead), .SirAddr(SirAddr), .SirWdat(SirWdat),
        .SirDack(SirDack), .SirRdat(SirRdat)
    );

    // Sir slave model: registers 0x00..0x3F, acks one cycle after the rising edge of select.
    logic [31:0] mem [0:63];
    logic        selD = 1'b0;
    logic        slvInit = 1'b1;
    always @(posedge clk) begin
        if (slvInit) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            SirDack <= 1'b0;
            SirRdat <= '0;
            selD    <= 1'b0;
        end else begin
            selD <= SirSel;
            if (SirSel && !selD && (SirAddr < 8'h40)) begin
                SirDack <= 1'b1;
                if (SirRead) SirRdat <= mem[SirAddr[5:0]];
                else begin
                    mem[SirAddr[5:0]] <= SirWdat;
                    SirRdat <= '0;
                end
            end else begin
                SirDack <= 1'b0;
                SirRdat <= '0;
            end
        end
    end

    // Low-time monitor between SirSel pulses.
    int  lowRun = 0, gapViol = 0, minGap = 1000;
    bit  prevSel = 0, seenPulse = 0;
    always @(negedge clk) begin
        if (SirSel && !prevSel) begin
            if (seenPulse) begin
                if (lowRun < 2) gapViol++;
                if (lowRun < minGap) minGap = lowRun;
            end
            seenPulse = 1;
        end
        if (!SirSel) lowRun++;
        else lowRun = 0;
        prevSel = SirSel;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic runTxn(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          output int selCyc, output int lat, output logic [1:0] resp,
                          output logic [31:0] rd, output bit busOk);
        int g;
        selCyc = 0; lat = 0; resp = 2'b00; rd = '0; busOk = 1;
        @(posedge clk); #1;
        if (wr) begin
            s_awvalid = 1; s_wvalid = 1; s_awaddr = a; s_wdata = d;
        end else begin
            s_arvalid = 1; s_araddr = a;
        end
        @(negedge clk);
        g = 0;
        while (!(wr ? (s_awready && s_wready) : s_arready) && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_seen", 32'(g < 50), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        lat = 1;
        while (lat < 400) begin
            @(negedge clk);
            if (SirSel) begin
                selCyc++;
                if (SirRead !== !wr || SirAddr !== a || SirWdat !== (wr ? d : 32'd0)) busOk = 0;
            end
            if (wr ? s_bvalid : s_rvalid) break;
            lat++;
        end
        resp = wr ? s_bresp : s_rresp;
        rd   = s_rdata;
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] expRdata;
        logic [1:0]  expResp;
        int          expSel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int selCyc, lat;
        logic [1:0] resp;
        logic [31:0] rd;
        bit busOk;

        vecs[0] = '{1, 8'h01, 32'h5A,       32'h0,        2'b00, 3};
        vecs[1] = '{0, 8'h01, 32'h0,        32'h5A,       2'b00, 3};
        vecs[2] = '{1, 8'h3F, 32'h12345678, 32'h0,        2'b00, 3};
        vecs[3] = '{0, 8'h3F, 32'h0,        32'h12345678, 2'b00, 3};
        vecs[4] = '{0, 8'h02, 32'h0,        32'h0,        2'b00, 3};
        vecs[5] = '{0, 8'h7F, 32'h0,        32'hDEADBEEF, 2'b10, 255};
        vecs[6] = '{1, 8'h7F, 32'hCAFE,     32'h0,        2'b10, 255};
        vecs[7] = '{0, 8'h3F, 32'h0,        32'h12345678, 2'b00, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctl", {23'd0, SirSel, SirRead, s_bvalid, s_rvalid, s_awready, s_wready,
                          s_arready, s_bresp, s_rresp}, 32'd0);
        chk("reset_addr", {24'd0, SirAddr}, 32'd0);
        chk("reset_wdat", SirWdat, 32'd0);
        chk("reset_rdata", s_rdata, 32'd0);
        slvInit = 0;
        rst = 0;
        @(negedge clk);
        chk("post_reset_sel", {31'd0, SirSel}, 32'd0);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            runTxn(vecs[i].wr, vecs[i].addr, vecs[i].data, selCyc, lat, resp, rd, busOk);
            chk($sformatf("v%0d_sel_cycles", i), 32'(selCyc), 32'(vecs[i].expSel));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expSel + 1));
            chk($sformatf("v%0d_resp", i), {30'd0, resp}, {30'd0, vecs[i].expResp});
            chk($sformatf("v%0d_bus", i), {31'd0, busOk}, 32'd1);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, vecs[i].expRdata);
        end

        // Simultaneous write and read requests, twice each: expect W R W R
        begin
            int wl, rl, resps, ri, g;
            logic [3:0] ordBits;
            logic [31:0] rds [2];
            bit aw, ar;
            wl = 2; rl = 2; resps = 0; ri = 0; g = 0; ordBits = '0;
            rds[0] = '0; rds[1] = '0;
            @(posedge clk); #1;
            s_awvalid = 1; s_wvalid = 1; s_awaddr = 8'h10; s_wdata = 32'hA1;
            s_arvalid = 1; s_araddr = 8'h10;
            while (resps < 4 && g < 300) begin
                @(negedge clk);
                g++;
                aw = s_awready && s_wready;
                ar = s_arready;
                if (aw) ordBits = {ordBits[2:0], 1'b1};
                if (ar) ordBits = {ordBits[2:0], 1'b0};
                if (s_rvalid) begin
                    if (ri < 2) rds[ri] = s_rdata;
                    ri++;
                    resps++;
                end
                if (s_bvalid) resps++;
                @(posedge clk); #1;
                if (aw) begin
                    wl--;
                    if (wl == 0) begin s_awvalid = 0; s_wvalid = 0; end
                    else begin s_awaddr = 8'h11; s_wdata = 32'hA2; end
                end
                if (ar) begin
                    rl--;
                    if (rl == 0) s_arvalid = 0;
                    else s_araddr = 8'h11;
                end
            end
            s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
            chk("arb_done", 32'(resps), 32'd4);
            chk("arb_order", {28'd0, ordBits}, 32'hA);
            chk("arb_rd0", rds[0], 32'hA1);
            chk("arb_rd1", rds[1], 32'hA2);
        end

        // Back-pressure on the write response
        begin
            int g, n, heldBad;
            s_bready = 0;
            @(posedge clk); #1;
            s_awvalid = 1; s_wvalid = 1; s_awaddr = 8'h05; s_wdata = 32'h77;
            g = 0;
            @(negedge clk);
            while (!s_awready && g < 50) begin @(negedge clk); g++; end
            @(posedge clk); #1;
            s_awvalid = 0; s_wvalid = 0;
            s_arvalid = 1; s_araddr = 8'h05;
            g = 0;
            @(negedge clk);
            while (!s_bvalid && g < 50) begin @(negedge clk); g++; end
            chk("bp_bvalid_seen", {31'd0, s_bvalid}, 32'd1);
            heldBad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!s_bvalid || s_bresp !== 2'b00 || SirSel || s_arready) heldBad++;
            end
            chk("bp_held", 32'(heldBad), 32'd0);
            @(posedge clk); #1;
            s_bready = 1;
            @(negedge clk);
            chk("bp_handshake", {31'd0, s_bvalid}, 32'd1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_arready && n < 20);
            chk("bp_ar_after_gap", 32'(n), 32'd3);
            @(posedge clk); #1;
            s_arvalid = 0;
            g = 0;
            @(negedge clk);
            while (!s_rvalid && g < 50) begin @(negedge clk); g++; end
            chk("bp_rdata", s_rdata, 32'h77);
            chk("bp_rresp", {30'd0, s_rresp}, 32'd0);
        end

        // Reset pulse in the middle of an access
        begin
            int g, spur;
            @(posedge clk); #1;
            s_awvalid = 1; s_wvalid = 1; s_awaddr = 8'h06; s_wdata = 32'h99;
            g = 0;
            @(negedge clk);
            while (!s_awready && g < 50) begin @(negedge clk); g++; end
            @(posedge clk); #1;
            s_awvalid = 0; s_wvalid = 0;
            @(negedge clk);
            chk("rst_sel_before", {31'd0, SirSel}, 32'd1);
            #2 rst = 1;
            #1;
            chk("rst_outputs", {29'd0, SirSel, s_bvalid, s_rvalid}, 32'd0);
            @(negedge clk);
            rst = 0;
            spur = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (s_bvalid || s_rvalid || SirSel) spur++;
            end
            chk("rst_no_resp", 32'(spur), 32'd0);
            runTxn(1, 8'h06, 32'h55, selCyc, lat, resp, rd, busOk);
            chk("rst_wr_lat", 32'(lat), 32'd4);
            chk("rst_wr_resp", {30'd0, resp}, 32'd0);
            runTxn(0, 8'h06, 32'h0, selCyc, lat, resp, rd, busOk);
            chk("rst_rd_data", rd, 32'h55);
        end

        chk("gap_violations", 32'(gapViol), 32'd0);
        chk("min_gap", 32'(minGap), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
